// File: rtl/vga_scanout_pkg.sv
// Shared timing defaults, framebuffer geometry and helpers for the VGA scanout block.
package vga_scanout_pkg;

  // 640x480 @ 60 Hz defaults (25 MHz pixel clock)
  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;

  // Framebuffer geometry: each framebuffer pixel covers a 4x4 screen block
  localparam int unsigned FB_W     = 160;
  localparam int unsigned FB_H     = 120;
  localparam int unsigned FB_DEPTH = FB_W * FB_H;

  localparam int unsigned CNT_W    = 10;
  localparam int unsigned ADDR_W   = 15;
  localparam int unsigned COLOR_W  = 3;
  localparam int unsigned FX_W     = 8;
  localparam int unsigned FY_W     = 7;
  localparam int unsigned PIPE_LAT = 3;

  // Sync/qualifier bundle carried alongside the pixel pipeline
  typedef struct packed {
    logic hs;
    logic vs;
    logic vis;
    logic fs;
  } sync_t;

  localparam sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, vis: 1'b0, fs: 1'b0};

  // y*160 + x built from shifts: 160 = 128 + 32
  function automatic logic [ADDR_W-1:0] fb_addr(input logic [FY_W-1:0] fy,
                                                input logic [FX_W-1:0] fx);
    return ADDR_W'({fy, 7'd0}) + ADDR_W'({fy, 5'd0}) + ADDR_W'(fx);
  endfunction

  // One colour bit widened to a full-scale 8-bit channel
  function automatic logic [7:0] expand(input logic b);
    return b ? 8'hFF : 8'h00;
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Horizontal/vertical counters and raw (undelayed) sync, visible and frame-start strobes.
module vga_timing
  import vga_scanout_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic [FX_W-1:0] fx_c,
  output logic [FY_W-1:0] fy_c,
  output logic            hs_c,
  output logic            vs_c,
  output logic            visible_c,
  output logic            frame_start_c
);

  localparam logic [CNT_W-1:0] H_MAX    = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CNT_W-1:0] V_MAX    = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [CNT_W-1:0] hcount;
  logic [CNT_W-1:0] vcount;

  // Pixel/line counters; vcount only moves on the hcount wrap
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hcount <= '0;
      vcount <= '0;
    end else if (hcount == H_MAX) begin
      hcount <= '0;
      vcount <= (vcount == V_MAX) ? '0 : vcount + CNT_W'(1);
    end else begin
      hcount <= hcount + CNT_W'(1);
    end
  end

  // Stage-0 decodes straight off the counters
  always_comb begin
    visible_c     = (hcount < H_VIS) && (vcount < V_VIS);
    hs_c          = !((hcount >= HS_START) && (hcount < HS_END));
    vs_c          = !((vcount >= VS_START) && (vcount < VS_END));
    frame_start_c = (hcount == '0) && (vcount == '0);
    fx_c          = hcount[9:2];
    fy_c          = vcount[8:2];
  end

endmodule

// File: rtl/vga_scanout.sv
// Framebuffer scanout: address generation, 3-clk sync alignment and colour expansion.
module vga_scanout
  import vga_scanout_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [COLOR_W-1:0] mem_rdata,
  output logic [7:0]         vga_r,
  output logic [7:0]         vga_g,
  output logic [7:0]         vga_b,
  output logic               vga_hs,
  output logic               vga_vs,
  output logic               vga_blank_n,
  output logic               frame_start
);

  logic [FX_W-1:0] fx_c;
  logic [FY_W-1:0] fy_c;
  logic            hs_c;
  logic            vs_c;
  logic            visible_c;
  logic            frame_start_c;

  sync_t sync_raw;
  sync_t sync_d1;
  sync_t sync_d2;

  vga_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk           (clk),
    .reset_n       (reset_n),
    .fx_c          (fx_c),
    .fy_c          (fy_c),
    .hs_c          (hs_c),
    .vs_c          (vs_c),
    .visible_c     (visible_c),
    .frame_start_c (frame_start_c)
  );

  assign sync_raw = '{hs: hs_c, vs: vs_c, vis: visible_c, fs: frame_start_c};

  // Stage 1: framebuffer read address, parked at 0 outside the visible area
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_addr <= '0;
    end else begin
      mem_addr <= visible_c ? fb_addr(fy_c, fx_c) : '0;
    end
  end

  // Stages 1-2: carry syncs alongside the memory read so they meet the colour data
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_d1 <= SYNC_IDLE;
      sync_d2 <= SYNC_IDLE;
    end else begin
      sync_d1 <= sync_raw;
      sync_d2 <= sync_d1;
    end
  end

  // Stage 3: output pins; colour forced black whenever the aligned pixel is blanked
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_blank_n <= 1'b0;
      frame_start <= 1'b0;
      vga_r       <= 8'h00;
      vga_g       <= 8'h00;
      vga_b       <= 8'h00;
    end else begin
      vga_hs      <= sync_d2.hs;
      vga_vs      <= sync_d2.vs;
      vga_blank_n <= sync_d2.vis;
      frame_start <= sync_d2.fs;
      vga_r       <= sync_d2.vis ? expand(mem_rdata[2]) : 8'h00;
      vga_g       <= sync_d2.vis ? expand(mem_rdata[1]) : 8'h00;
      vga_b       <= sync_d2.vis ? expand(mem_rdata[0]) : 8'h00;
    end
  end

endmodule
